// File: rtl/wt_cache_pkg.sv
// Write-through cache package slice: payload types for the instruction cache
// AXI refill engine.
//   icache_refill_req_t : queued request {paddr, nc, tid}
//   icache_refill_trk_t : tracked in-flight read {tid, nc, kill}
package wt_cache_pkg;

  localparam int unsigned IcachePlenWidth = 56;
  localparam int unsigned IcacheIdWidth   = 4;

  typedef struct packed {
    logic [IcachePlenWidth-1:0] paddr;
    logic                       nc;
    logic [IcacheIdWidth-1:0]   tid;
  } icache_refill_req_t;

  typedef struct packed {
    logic [IcacheIdWidth-1:0] tid;
    logic                     nc;
    logic                     kill;
  } icache_refill_trk_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with registered storage and synchronous active-low
// reset. Exposes its read/write slot indices so side-band state can be kept
// per entry outside the FIFO.
//   push_i/pop_i     : enqueue / dequeue (ignored when full / empty)
//   flush_i          : empty the FIFO
//   data_o           : head entry
//   wr_idx_o/rd_idx_o: slot that the next push writes / that data_o reads
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  localparam int unsigned PtrWidth  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [PtrWidth-1:0]   wr_idx_o,
  output logic [PtrWidth-1:0]   rd_idx_o
);

  localparam int unsigned CntWidth = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrWidth-1:0]   wr_q, rd_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  do_push, do_pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full_o   = (cnt_q == CntWidth'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign data_o   = mem_q[rd_q];
  assign wr_idx_o = wr_q;
  assign rd_idx_o = rd_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      cnt_q <= cnt_q + CntWidth'(do_push) - CntWidth'(do_pop);
    end
  end

  // Storage needs no reset; empty_o qualifies data_o.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cva6_icache_axi_refill.sv
// Instruction cache refill engine in front of the read side of axi_shim.
// Queues miss/bypass requests, issues up to MaxOutstanding AXI reads, folds
// each burst into one line and returns it with tid and error; reads in
// flight at a flush are completed on the bus but not returned.
//   req_*  : cache request handshake (req_ack_o is combinational)
//   rd_*   : shim AR request/grant and R beat input
//   rtrn_* : registered line return, rtrn_vld_o pulses one cycle
//   busy_o : requests queued or reads outstanding
module cva6_icache_axi_refill
  import wt_cache_pkg::*;
#(
  parameter int unsigned LineWidth      = 128,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned PlenWidth      = 56,
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic                                    req_valid_i,
  output logic                                    req_ack_o,
  input  logic [PlenWidth-1:0]                    req_paddr_i,
  input  logic                                    req_nc_i,
  input  logic [IdWidth-1:0]                      req_tid_i,
  output logic                                    rd_req_o,
  input  logic                                    rd_gnt_i,
  output logic [63:0]                             rd_addr_o,
  output logic [$clog2(LineWidth/AxiDataWidth):0] rd_blen_o,
  output logic [2:0]                              rd_size_o,
  output logic [IdWidth-1:0]                      rd_id_o,
  input  logic                                    rd_valid_i,
  input  logic                                    rd_last_i,
  input  logic [AxiDataWidth-1:0]                 rd_data_i,
  input  logic                                    rd_err_i,
  output logic                                    rtrn_vld_o,
  output logic [LineWidth-1:0]                    rtrn_data_o,
  output logic [IdWidth-1:0]                      rtrn_tid_o,
  output logic                                    rtrn_err_o,
  output logic                                    busy_o
);

  localparam int unsigned BeatsPerLine = LineWidth / AxiDataWidth;
  localparam int unsigned BlenWidth    = $clog2(BeatsPerLine) + 1;
  localparam int unsigned OutWidth     = $clog2(MaxOutstanding + 1);
  localparam int unsigned TrkIdxWidth  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [63:0] LineMask     = ~64'(LineWidth / 8 - 1);
  localparam logic [63:0] BeatMask     = ~64'(AxiDataWidth / 8 - 1);

  icache_refill_req_t          req_in, req_head;
  icache_refill_trk_t          trk_in, trk_head;
  logic                        req_full, req_empty, trk_full, trk_empty;
  logic [TrkIdxWidth-1:0]      req_wr_idx, req_rd_idx;
  logic [TrkIdxWidth-1:0]      trk_wr_idx, trk_rd_idx;
  logic [MaxOutstanding-1:0]   kill_q;
  logic [OutWidth-1:0]         out_q;
  logic                        trk_push, trk_pop, beat, head_kill;
  logic                        first_q, err_q, err_d;
  logic [LineWidth-1:0]        line_q, line_d;

  // Request side.
  assign req_ack_o    = req_valid_i & ~flush_i & ~req_full;
  assign req_in.paddr = IcachePlenWidth'(req_paddr_i);
  assign req_in.nc    = req_nc_i;
  assign req_in.tid   = IcacheIdWidth'(req_tid_i);

  fifo_v3 #(
    .DATA_WIDTH ($bits(icache_refill_req_t)),
    .DEPTH      (ReqDepth)
  ) i_req_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .push_i   (req_ack_o),
    .pop_i    (trk_push),
    .data_i   (req_in),
    .full_o   (req_full),
    .empty_o  (req_empty),
    .data_o   (req_head),
    .wr_idx_o (req_wr_idx),
    .rd_idx_o (req_rd_idx)
  );

  // AR issue straight from the queue head; held stable until granted.
  assign rd_req_o  = ~req_empty & ~trk_full & (out_q < OutWidth'(MaxOutstanding));
  assign rd_addr_o = 64'(req_head.paddr) & (req_head.nc ? BeatMask : LineMask);
  assign rd_blen_o = req_head.nc ? '0 : BlenWidth'(BeatsPerLine - 1);
  assign rd_size_o = 3'($clog2(AxiDataWidth / 8));
  assign rd_id_o   = IdWidth'(req_head.tid);
  assign trk_push  = rd_req_o & rd_gnt_i;

  assign trk_in.tid  = req_head.tid;
  assign trk_in.nc   = req_head.nc;
  assign trk_in.kill = 1'b0;

  // Beats are only meaningful while a read is tracked.
  assign beat    = rd_valid_i & ~trk_empty;
  assign trk_pop = beat & rd_last_i;

  fifo_v3 #(
    .DATA_WIDTH ($bits(icache_refill_trk_t)),
    .DEPTH      (MaxOutstanding)
  ) i_trk_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (1'b0),
    .push_i   (trk_push),
    .pop_i    (trk_pop),
    .data_i   (trk_in),
    .full_o   (trk_full),
    .empty_o  (trk_empty),
    .data_o   (trk_head),
    .wr_idx_o (trk_wr_idx),
    .rd_idx_o (trk_rd_idx)
  );

  assign head_kill = trk_head.kill | kill_q[trk_rd_idx];
  assign busy_o    = ~req_empty | (out_q != '0);

  // Flush marks every slot killed, which also covers a push in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      kill_q <= '0;
    end else if (flush_i) begin
      kill_q <= '1;
    end else if (trk_push) begin
      kill_q[trk_wr_idx] <= 1'b0;
    end
  end

  // Outstanding read count, saturating at both ends.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else if (trk_push && !trk_pop && out_q != OutWidth'(MaxOutstanding)) begin
      out_q <= out_q + OutWidth'(1);
    end else if (trk_pop && !trk_push && out_q != '0) begin
      out_q <= out_q - OutWidth'(1);
    end
  end

  // Beat assembly: shift into the top word; a bypass beat also lands in word 0.
  always_comb begin
    line_d = line_q;
    err_d  = err_q;
    if (beat) begin
      line_d = line_q >> AxiDataWidth;
      line_d[LineWidth-1 -: AxiDataWidth] = rd_data_i;
      if (first_q && trk_head.nc) line_d[AxiDataWidth-1:0] = rd_data_i;
      err_d = first_q ? rd_err_i : (err_q | rd_err_i);
    end
  end

  // Accumulator survives flush so a killed burst still drains cleanly.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      line_q  <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      line_q <= line_d;
      err_q  <= err_d;
      if (beat) first_q <= rd_last_i;
    end
  end

  // Registered line return.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rtrn_vld_o  <= 1'b0;
      rtrn_data_o <= '0;
      rtrn_tid_o  <= '0;
      rtrn_err_o  <= 1'b0;
    end else begin
      rtrn_vld_o <= trk_pop & ~head_kill;
      if (trk_pop && !head_kill) begin
        rtrn_data_o <= line_d;
        rtrn_tid_o  <= IdWidth'(trk_head.tid);
        rtrn_err_o  <= err_d;
      end
    end
  end

  // A last beat with nothing tracked is a bus protocol violation.
  a_last_needs_tracked_read: assert property (
    @(posedge clk_i) disable iff (!rst_ni) (rd_valid_i && rd_last_i) |-> !trk_empty
  );

endmodule

// File: tb/tb_cva6_icache_axi_refill.sv
// Self-checking bench for cva6_icache_axi_refill: directed scenarios plus a
// randomized stream, compared against an address/line model built from the
// request and beat values.
module tb_cva6_icache_axi_refill;

  localparam int unsigned LineWidth      = 128;
  localparam int unsigned AxiDataWidth   = 64;
  localparam int unsigned IdWidth        = 4;
  localparam int unsigned PlenWidth      = 56;
  localparam int unsigned ReqDepth       = 2;
  localparam int unsigned MaxOutstanding = 2;
  localparam int unsigned Beats          = LineWidth / AxiDataWidth;
  localparam int unsigned BlenW          = $clog2(Beats) + 1;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    flush_i = 1'b0;
  logic                    req_valid_i = 1'b0;
  logic                    req_ack_o;
  logic [PlenWidth-1:0]    req_paddr_i = '0;
  logic                    req_nc_i = 1'b0;
  logic [IdWidth-1:0]      req_tid_i = '0;
  logic                    rd_req_o;
  logic                    rd_gnt_i = 1'b0;
  logic [63:0]             rd_addr_o;
  logic [BlenW-1:0]        rd_blen_o;
  logic [2:0]              rd_size_o;
  logic [IdWidth-1:0]      rd_id_o;
  logic                    rd_valid_i = 1'b0;
  logic                    rd_last_i = 1'b0;
  logic [AxiDataWidth-1:0] rd_data_i = '0;
  logic                    rd_err_i = 1'b0;
  logic                    rtrn_vld_o;
  logic [LineWidth-1:0]    rtrn_data_o;
  logic [IdWidth-1:0]      rtrn_tid_o;
  logic                    rtrn_err_o;
  logic                    busy_o;

  int total = 0;
  int bad   = 0;

  typedef logic [AxiDataWidth-1:0] beat_arr_t [Beats];
  typedef bit                      err_arr_t  [Beats];

  cva6_icache_axi_refill #(
    .LineWidth(LineWidth), .AxiDataWidth(AxiDataWidth), .IdWidth(IdWidth),
    .PlenWidth(PlenWidth), .ReqDepth(ReqDepth), .MaxOutstanding(MaxOutstanding)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ack_o(req_ack_o), .req_paddr_i(req_paddr_i),
    .req_nc_i(req_nc_i), .req_tid_i(req_tid_i),
    .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o),
    .rd_blen_o(rd_blen_o), .rd_size_o(rd_size_o), .rd_id_o(rd_id_o),
    .rd_valid_i(rd_valid_i), .rd_last_i(rd_last_i), .rd_data_i(rd_data_i),
    .rd_err_i(rd_err_i),
    .rtrn_vld_o(rtrn_vld_o), .rtrn_data_o(rtrn_data_o), .rtrn_tid_o(rtrn_tid_o),
    .rtrn_err_o(rtrn_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: address rounded down to the access granule.
  function automatic logic [63:0] model_addr(input logic [PlenWidth-1:0] pa, input bit nc);
    longint unsigned a, gran;
    a    = longint'(64'(pa));
    gran = nc ? longint'(AxiDataWidth / 8) : longint'(LineWidth / 8);
    return 64'((a / gran) * gran);
  endfunction

  function automatic int unsigned model_blen(input bit nc);
    return nc ? 0 : Beats - 1;
  endfunction

  // Beat i lands in line word i.
  function automatic logic [LineWidth-1:0] model_line(input beat_arr_t d);
    logic [LineWidth-1:0] l;
    l = '0;
    for (int i = 0; i < Beats; i++) l[i*AxiDataWidth +: AxiDataWidth] = d[i];
    return l;
  endfunction

  function automatic bit model_err(input err_arr_t e, input int n);
    bit r;
    r = 1'b0;
    for (int i = 0; i < n; i++) r = r | e[i];
    return r;
  endfunction

  // Drive helpers (no checking): handshake a request, wait for AR, grant, send beats.
  task automatic push_req(input logic [PlenWidth-1:0] pa, input bit nc,
                          input logic [IdWidth-1:0] tid, output bit ok);
    ok = 1'b0;
    req_valid_i = 1'b1; req_paddr_i = pa; req_nc_i = nc; req_tid_i = tid;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ack_o) begin ok = 1'b1; @(negedge clk_i); break; end
      @(negedge clk_i);
    end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (rd_req_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
  endtask

  task automatic do_grant();
    rd_gnt_i = 1'b1;
    @(negedge clk_i);
    rd_gnt_i = 1'b0;
  endtask

  task automatic issue(input logic [PlenWidth-1:0] pa, input bit nc, input logic [IdWidth-1:0] tid,
                       output bit ok, output logic [63:0] a, output logic [BlenW-1:0] bl,
                       output logic [2:0] sz, output logic [IdWidth-1:0] id);
    bit ok1, ok2;
    push_req(pa, nc, tid, ok1);
    wait_req(ok2);
    a = rd_addr_o; bl = rd_blen_o; sz = rd_size_o; id = rd_id_o;
    ok = ok1 & ok2;
    if (ok) do_grant();
  endtask

  task automatic burst(input beat_arr_t d, input err_arr_t e, input int n);
    for (int i = 0; i < n; i++) begin
      rd_valid_i = 1'b1; rd_data_i = d[i]; rd_err_i = e[i]; rd_last_i = (i == n - 1);
      @(negedge clk_i);
    end
    rd_valid_i = 1'b0; rd_last_i = 1'b0; rd_err_i = 1'b0; rd_data_i = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
    total++; if (req_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", req_ack_o); end
    total++; if (rd_req_o !== 1'b0) begin bad++; $display("FAIL reset_rd_req got=%b exp=0", rd_req_o); end
    total++; if (rtrn_vld_o !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", rtrn_vld_o); end
    total++; if (rtrn_data_o !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", rtrn_data_o); end
    total++; if (rtrn_tid_o !== '0) begin bad++; $display("FAIL reset_tid got=%h exp=0", rtrn_tid_o); end
    total++; if (rtrn_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", rtrn_err_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_cacheable();
    bit ok; logic [63:0] a; logic [BlenW-1:0] bl; logic [2:0] sz; logic [IdWidth-1:0] id;
    beat_arr_t d; err_arr_t e;
    logic [PlenWidth-1:0] pa;
    pa = PlenWidth'(64'h8000_0014);
    d[0] = 64'hA; d[1] = 64'hB; e[0] = 0; e[1] = 0;
    issue(pa, 1'b0, 4'd3, ok, a, bl, sz, id);
    total++; if (!ok) begin bad++; $display("FAIL cach_issue timeout"); end
    total++; if (a !== model_addr(pa, 0)) begin bad++; $display("FAIL cach_addr got=%h exp=%h", a, model_addr(pa, 0)); end
    total++; if (bl !== BlenW'(model_blen(0))) begin bad++; $display("FAIL cach_blen got=%0d exp=%0d", bl, model_blen(0)); end
    total++; if (sz !== 3'($clog2(AxiDataWidth / 8))) begin bad++; $display("FAIL cach_size got=%0d", sz); end
    total++; if (id !== 4'd3) begin bad++; $display("FAIL cach_id got=%0d exp=3", id); end
    burst(d, e, Beats);
    total++; if (rtrn_vld_o !== 1'b1) begin bad++; $display("FAIL cach_vld got=%b exp=1", rtrn_vld_o); end
    total++; if (rtrn_data_o !== model_line(d)) begin bad++; $display("FAIL cach_data got=%h exp=%h", rtrn_data_o, model_line(d)); end
    total++; if (rtrn_tid_o !== 4'd3) begin bad++; $display("FAIL cach_tid got=%0d exp=3", rtrn_tid_o); end
    total++; if (rtrn_err_o !== 1'b0) begin bad++; $display("FAIL cach_err got=%b exp=0", rtrn_err_o); end
    @(negedge clk_i);
    total++; if (rtrn_vld_o !== 1'b0) begin bad++; $display("FAIL cach_vld_pulse got=%b exp=0", rtrn_vld_o); end
  endtask

  task automatic test_noncacheable();
    bit ok; logic [63:0] a; logic [BlenW-1:0] bl; logic [2:0] sz; logic [IdWidth-1:0] id;
    beat_arr_t d; err_arr_t e;
    logic [PlenWidth-1:0] pa;
    pa = PlenWidth'(64'h1000_0008);
    d[0] = 64'hCAFE; d[1] = '0; e[0] = 0; e[1] = 0;
    issue(pa, 1'b1, 4'd7, ok, a, bl, sz, id);
    total++; if (!ok) begin bad++; $display("FAIL nc_issue timeout"); end
    total++; if (a !== model_addr(pa, 1)) begin bad++; $display("FAIL nc_addr got=%h exp=%h", a, model_addr(pa, 1)); end
    total++; if (bl !== '0) begin bad++; $display("FAIL nc_blen got=%0d exp=0", bl); end
    burst(d, e, 1);
    total++; if (rtrn_vld_o !== 1'b1) begin bad++; $display("FAIL nc_vld got=%b exp=1", rtrn_vld_o); end
    total++; if (rtrn_data_o[AxiDataWidth-1:0] !== d[0]) begin bad++; $display("FAIL nc_word0 got=%h exp=%h", rtrn_data_o[AxiDataWidth-1:0], d[0]); end
    total++; if (rtrn_tid_o !== 4'd7) begin bad++; $display("FAIL nc_tid got=%0d exp=7", rtrn_tid_o); end
  endtask

  task automatic test_error();
    bit ok; logic [63:0] a; logic [BlenW-1:0] bl; logic [2:0] sz; logic [IdWidth-1:0] id;
    beat_arr_t d; err_arr_t e;
    d[0] = 64'h1111; d[1] = 64'h2222; e[0] = 1; e[1] = 0;
    issue(PlenWidth'(64'h4000_0040), 1'b0, 4'd9, ok, a, bl, sz, id);
    total++; if (!ok) begin bad++; $display("FAIL err_issue timeout"); end
    burst(d, e, Beats);
    total++; if (rtrn_err_o !== model_err(e, Beats)) begin bad++; $display("FAIL err_flag got=%b exp=1", rtrn_err_o); end
    total++; if (rtrn_tid_o !== 4'd9) begin bad++; $display("FAIL err_tid got=%0d exp=9", rtrn_tid_o); end
  endtask

  task automatic test_backpressure();
    int acc; bit got, ok;
    beat_arr_t d; err_arr_t e;
    e[0] = 0; e[1] = 0;
    acc = 0;
    for (int k = 0; k <= ReqDepth; k++) begin
      req_valid_i = 1'b1; req_nc_i = 1'b0; req_tid_i = IdWidth'(10 + k);
      req_paddr_i = PlenWidth'(64'h2000_0000 + 64'(k) * 64);
      got = 1'b0;
      for (int c = 0; c < 4; c++) begin
        #1;
        if (req_ack_o) begin got = 1'b1; @(negedge clk_i); break; end
        @(negedge clk_i);
      end
      if (got) acc++;
    end
    #1;
    total++; if (acc !== ReqDepth) begin bad++; $display("FAIL bp_accepts got=%0d exp=%0d", acc, ReqDepth); end
    total++; if (req_ack_o !== 1'b0) begin bad++; $display("FAIL bp_ack_full got=%b exp=0", req_ack_o); end
    req_valid_i = 1'b0;
    total++; if (rd_id_o !== 4'd10) begin bad++; $display("FAIL bp_first_id got=%0d exp=10", rd_id_o); end
    do_grant();
    push_req(PlenWidth'(64'h2000_0080), 1'b0, 4'd12, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_resume_ack timeout"); end
    for (int j = 0; j <= ReqDepth; j++) begin
      if (j > 0) begin
        wait_req(ok);
        total++; if (!ok || rd_id_o !== IdWidth'(10 + j)) begin bad++; $display("FAIL bp_id got=%0d exp=%0d", rd_id_o, 10 + j); end
        if (ok) do_grant();
      end
      d[0] = AxiDataWidth'(64'h100 + j); d[1] = AxiDataWidth'(64'h200 + j);
      burst(d, e, Beats);
      total++; if (rtrn_vld_o !== 1'b1 || rtrn_tid_o !== IdWidth'(10 + j)) begin bad++; $display("FAIL bp_ret vld=%b tid=%0d exp_tid=%0d", rtrn_vld_o, rtrn_tid_o, 10 + j); end
      total++; if (rtrn_data_o !== model_line(d)) begin bad++; $display("FAIL bp_data got=%h exp=%h", rtrn_data_o, model_line(d)); end
    end
  endtask

  task automatic test_two_outstanding();
    bit ok; beat_arr_t d1, d2, d4; err_arr_t e;
    e[0] = 0; e[1] = 0;
    d1[0] = 64'h11; d1[1] = 64'h12; d2[0] = 64'h21; d2[1] = 64'h22; d4[0] = 64'h41; d4[1] = 64'h42;
    push_req(PlenWidth'(64'h3000_0000), 1'b0, 4'd1, ok);
    push_req(PlenWidth'(64'h3000_0100), 1'b0, 4'd2, ok);
    wait_req(ok);
    total++; if (!ok || rd_id_o !== 4'd1) begin bad++; $display("FAIL two_id1 got=%0d exp=1", rd_id_o); end
    rd_gnt_i = 1'b1;
    @(negedge clk_i); #1;
    total++; if (rd_req_o !== 1'b1 || rd_id_o !== 4'd2) begin bad++; $display("FAIL two_b2b req=%b id=%0d exp id=2", rd_req_o, rd_id_o); end
    @(negedge clk_i);
    rd_gnt_i = 1'b0;
    push_req(PlenWidth'(64'h3000_0200), 1'b0, 4'd4, ok);
    #1;
    total++; if (rd_req_o !== 1'b0) begin bad++; $display("FAIL two_limit got=%b exp=0", rd_req_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL two_busy got=%b exp=1", busy_o); end
    burst(d1, e, Beats);
    total++; if (rtrn_vld_o !== 1'b1 || rtrn_tid_o !== 4'd1 || rtrn_data_o !== model_line(d1)) begin bad++; $display("FAIL two_ret1 vld=%b tid=%0d data=%h", rtrn_vld_o, rtrn_tid_o, rtrn_data_o); end
    #1;
    total++; if (rd_req_o !== 1'b1) begin bad++; $display("FAIL two_slot_free got=%b exp=1", rd_req_o); end
    burst(d2, e, Beats);
    total++; if (rtrn_vld_o !== 1'b1 || rtrn_tid_o !== 4'd2 || rtrn_data_o !== model_line(d2)) begin bad++; $display("FAIL two_ret2 vld=%b tid=%0d data=%h", rtrn_vld_o, rtrn_tid_o, rtrn_data_o); end
    wait_req(ok);
    if (ok) do_grant();
    burst(d4, e, Beats);
    total++; if (rtrn_vld_o !== 1'b1 || rtrn_tid_o !== 4'd4) begin bad++; $display("FAIL two_ret4 vld=%b tid=%0d exp=4", rtrn_vld_o, rtrn_tid_o); end
  endtask

  task automatic test_flush();
    bit ok; logic [63:0] a; logic [BlenW-1:0] bl; logic [2:0] sz; logic [IdWidth-1:0] id;
    beat_arr_t d; err_arr_t e;
    e[0] = 0; e[1] = 0;
    issue(PlenWidth'(64'h5000_0000), 1'b0, 4'd5, ok, a, bl, sz, id);
    total++; if (!ok) begin bad++; $display("FAIL flush_issue timeout"); end
    rd_valid_i = 1'b1; rd_data_i = 64'hDEAD; rd_last_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; rd_data_i = 64'hBEEF; rd_last_i = 1'b1;
    @(negedge clk_i);
    rd_valid_i = 1'b0; rd_last_i = 1'b0;
    total++; if (rtrn_vld_o !== 1'b0) begin bad++; $display("FAIL flush_killed got=%b exp=0", rtrn_vld_o); end
    @(negedge clk_i);
    total++; if (rtrn_vld_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL flush_idle vld=%b busy=%b exp 0/0", rtrn_vld_o, busy_o); end
    push_req(PlenWidth'(64'h5000_0100), 1'b0, 4'd8, ok);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; #1;
    total++; if (rd_req_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL flush_queue req=%b busy=%b exp 0/0", rd_req_o, busy_o); end
    d[0] = 64'h61; d[1] = 64'h62;
    issue(PlenWidth'(64'h5000_0200), 1'b0, 4'd6, ok, a, bl, sz, id);
    total++; if (!ok || id !== 4'd6) begin bad++; $display("FAIL flush_next_id got=%0d exp=6", id); end
    burst(d, e, Beats);
    total++; if (rtrn_vld_o !== 1'b1 || rtrn_tid_o !== 4'd6 || rtrn_data_o !== model_line(d)) begin bad++; $display("FAIL flush_next_ret vld=%b tid=%0d data=%h", rtrn_vld_o, rtrn_tid_o, rtrn_data_o); end
  endtask

  task automatic test_random();
    bit ok, nc; logic [63:0] a; logic [BlenW-1:0] bl; logic [2:0] sz; logic [IdWidth-1:0] id, tid;
    logic [PlenWidth-1:0] pa; beat_arr_t d; err_arr_t e; int n;
    for (int t = 0; t < 24; t++) begin
      nc  = bit'($urandom_range(0, 1));
      tid = IdWidth'($urandom);
      pa  = PlenWidth'({$urandom, $urandom});
      n   = nc ? 1 : Beats;
      for (int i = 0; i < Beats; i++) begin
        d[i] = AxiDataWidth'({$urandom, $urandom});
        e[i] = ($urandom_range(0, 3) == 0) && (i < n);
      end
      issue(pa, nc, tid, ok, a, bl, sz, id);
      total++; if (!ok) begin bad++; $display("FAIL rnd_issue t=%0d timeout", t); end
      total++; if (a !== model_addr(pa, nc)) begin bad++; $display("FAIL rnd_addr t=%0d got=%h exp=%h", t, a, model_addr(pa, nc)); end
      total++; if (bl !== BlenW'(model_blen(nc)) || id !== tid) begin bad++; $display("FAIL rnd_ar t=%0d blen=%0d id=%0d exp %0d/%0d", t, bl, id, model_blen(nc), tid); end
      burst(d, e, n);
      total++; if (rtrn_vld_o !== 1'b1 || rtrn_tid_o !== tid || rtrn_err_o !== model_err(e, n)) begin bad++; $display("FAIL rnd_ret t=%0d vld=%b tid=%0d err=%b exp tid=%0d err=%b", t, rtrn_vld_o, rtrn_tid_o, rtrn_err_o, tid, model_err(e, n)); end
      if (nc) begin
        total++; if (rtrn_data_o[AxiDataWidth-1:0] !== d[0]) begin bad++; $display("FAIL rnd_word0 t=%0d got=%h exp=%h", t, rtrn_data_o[AxiDataWidth-1:0], d[0]); end
      end else begin
        total++; if (rtrn_data_o !== model_line(d)) begin bad++; $display("FAIL rnd_line t=%0d got=%h exp=%h", t, rtrn_data_o, model_line(d)); end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_cacheable();
    test_noncacheable();
    test_error();
    test_backpressure();
    test_two_outstanding();
    test_flush();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
